// File: rtl/hht_col_fetch_sched.sv
// HHT operand fetch sequencer: walks vsize elements of ncols matrix columns and streams
// (A[i][j], v[i]) pairs to the MAC datapath with a valid/ready handshake.
module hht_col_fetch_sched #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 16
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          start,
  input  logic [AW-1:0] v_values_base,
  input  logic [AW-1:0] wdata_col_base,
  input  logic [AW-1:0] csize,
  input  logic [CW-1:0] vsize,
  input  logic [CW-1:0] ncols,
  output logic [AW-1:0] addr1,
  output logic [AW-1:0] addr2,
  output logic          RD,
  input  logic [DW-1:0] dataIn1,
  input  logic [DW-1:0] dataIn2,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_v,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last_elem,
  output logic          out_last_col,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] v_base_q, v_base_d;
  logic [AW-1:0] csize_q, csize_d;
  logic [CW-1:0] vsize_q, vsize_d;
  logic [CW-1:0] ncols_q, ncols_d;
  logic [AW-1:0] col_ptr_q, col_ptr_d;
  logic [CW-1:0] i_q, i_d;
  logic [CW-1:0] j_q, j_d;

  logic streaming;
  logic last_elem;
  logic last_col;

  assign streaming = (state_q == StStream);
  assign last_elem = (i_q == vsize_q - CW'(1));
  assign last_col  = (j_q == ncols_q - CW'(1));

  always_comb begin
    state_d   = state_q;
    v_base_d  = v_base_q;
    csize_d   = csize_q;
    vsize_d   = vsize_q;
    ncols_d   = ncols_q;
    col_ptr_d = col_ptr_q;
    i_d       = i_q;
    j_d       = j_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          v_base_d  = v_values_base;
          csize_d   = csize;
          vsize_d   = vsize;
          ncols_d   = ncols;
          col_ptr_d = wdata_col_base;
          i_d       = '0;
          j_d       = '0;
          state_d   = (vsize == '0 || ncols == '0) ? StDone : StStream;
        end
      end
      StStream: begin
        if (out_ready) begin
          if (last_elem) begin
            // Column pointer advances by stride instead of multiplying j*csize.
            i_d       = '0;
            j_d       = j_q + CW'(1);
            col_ptr_d = col_ptr_q + csize_q;
            if (last_col) state_d = StDone;
          end else begin
            i_d = i_q + CW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q   <= StIdle;
      v_base_q  <= '0;
      csize_q   <= '0;
      vsize_q   <= '0;
      ncols_q   <= '0;
      col_ptr_q <= '0;
      i_q       <= '0;
      j_q       <= '0;
    end else begin
      state_q   <= state_d;
      v_base_q  <= v_base_d;
      csize_q   <= csize_d;
      vsize_q   <= vsize_d;
      ncols_q   <= ncols_d;
      col_ptr_q <= col_ptr_d;
      i_q       <= i_d;
      j_q       <= j_d;
    end
  end

  // Memories are async-read, so addresses are driven straight from the counters.
  assign addr1         = streaming ? col_ptr_q + AW'(i_q) : '0;
  assign addr2         = streaming ? v_base_q + AW'(i_q) : '0;
  assign RD            = streaming;
  assign out_valid     = streaming;
  assign out_last_elem = streaming & last_elem;
  assign out_last_col  = streaming & last_col;
  assign out_a         = dataIn1;
  assign out_v         = dataIn2;
  assign busy          = streaming;
  assign done          = (state_q == StDone);

endmodule

// File: tb/tb_hht_col_fetch_sched.sv
// Directed bench for hht_col_fetch_sched: vector table of whole jobs plus stall, restart and
// mid-job reset sequences, each pair checked against an address/data model.
module tb_hht_col_fetch_sched;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        start;
  logic [31:0] vb_in, cb_in, cs_in;
  logic [15:0] vs_in, nc_in;
  logic [31:0] addr1, addr2;
  logic        RD;
  logic [31:0] dataIn1, dataIn2;
  logic [31:0] out_a, out_v;
  logic        out_valid, out_ready, out_last_elem, out_last_col, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem1(input logic [31:0] a);
    return a * 32'd3 + 32'h0000_0100;
  endfunction

  function automatic logic [31:0] mem2(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  assign dataIn1 = mem1(addr1);
  assign dataIn2 = mem2(addr2);

  hht_col_fetch_sched #(.AW(32), .DW(32), .CW(16)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .start         (start),
    .v_values_base (vb_in),
    .wdata_col_base(cb_in),
    .csize         (cs_in),
    .vsize         (vs_in),
    .ncols         (nc_in),
    .addr1         (addr1),
    .addr2         (addr2),
    .RD            (RD),
    .dataIn1       (dataIn1),
    .dataIn2       (dataIn2),
    .out_a         (out_a),
    .out_v         (out_v),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last_elem (out_last_elem),
    .out_last_col  (out_last_col),
    .busy          (busy),
    .done          (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " addr1"}, addr1, 32'd0);
    chk({tag, " addr2"}, addr2, 32'd0);
    chk({tag, " RD"}, {31'd0, RD}, 32'd0);
    chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " last_elem"}, {31'd0, out_last_elem}, 32'd0);
    chk({tag, " last_col"}, {31'd0, out_last_col}, 32'd0);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " done"}, {31'd0, done}, 32'd0);
  endtask

  // Runs one job from IDLE; called and returning at #1 after a rising edge.
  task automatic run_job(input logic [31:0] vb, cb, cs, input logic [15:0] vs, nc,
                         input int stall_i, stall_len, poke_i, rst_i,
                         output int pairs, output int done_cyc,
                         output logic [31:0] la1, la2);
    int   cyc = 0, mi = 0, mj = 0, stall_cnt = 0;
    bit   streaming, exp_done, poked = 0, finished = 0;
    logic [31:0] ea1, ea2;
    logic rdy;
    vb_in = vb; cb_in = cb; cs_in = cs; vs_in = vs; nc_in = nc;
    start = 1'b1; out_ready = 1'b1;
    @(posedge Clk); #1; cyc = 1;
    start = 1'b0;
    // Scramble config inputs: latched values must be used.
    vb_in = 32'hDEAD_0000; cb_in = 32'hBEEF_0000; cs_in = 32'd7; vs_in = 16'd3; nc_in = 16'd5;
    streaming = (vs != 0) && (nc != 0);
    exp_done  = !streaming;
    pairs = 0; done_cyc = -1; la1 = '0; la2 = '0;
    while (!finished && cyc < 400) begin
      if (streaming) begin
        ea1 = cb + 32'(mj) * cs + 32'(mi);
        ea2 = vb + 32'(mi);
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        chk("RD", {31'd0, RD}, 32'd1);
        chk("busy", {31'd0, busy}, 32'd1);
        chk("done early", {31'd0, done}, 32'd0);
        chk("addr1", addr1, ea1);
        chk("addr2", addr2, ea2);
        chk("out_a", out_a, mem1(ea1));
        chk("out_v", out_v, mem2(ea2));
        chk("last_elem", {31'd0, out_last_elem}, {31'd0, (mi == int'(vs) - 1)});
        chk("last_col", {31'd0, out_last_col}, {31'd0, (mj == int'(nc) - 1)});
        if (rst_i >= 0 && mi == rst_i && mj == 0) begin
          Rst = 1'b0;
          @(posedge Clk); #1; cyc++;
          Rst = 1'b1;
          chk_idle("after reset");
          @(posedge Clk); #1; cyc++;
          chk("no done after reset", {31'd0, done}, 32'd0);
          chk("idle after reset", {31'd0, out_valid}, 32'd0);
          finished = 1;
        end else begin
          rdy = 1'b1;
          if (stall_i >= 0 && mi == stall_i && mj == 0 && stall_cnt < stall_len) begin
            rdy = 1'b0;
            stall_cnt++;
          end
          if (poke_i >= 0 && mi == poke_i && mj == 0 && !poked) begin
            start = 1'b1; cb_in = 32'd0; vb_in = 32'd0;
            poked = 1;
          end
          out_ready = rdy;
          if (rdy) begin
            pairs++; la1 = ea1; la2 = ea2;
            if (mi == int'(vs) - 1) begin
              mi = 0;
              if (mj == int'(nc) - 1) begin
                streaming = 0; exp_done = 1;
              end else begin
                mj++;
              end
            end else begin
              mi++;
            end
          end
          @(posedge Clk); #1; cyc++;
          start = 1'b0; out_ready = 1'b1;
        end
      end else if (exp_done) begin
        chk("done pulse", {31'd0, done}, 32'd1);
        chk("valid in done", {31'd0, out_valid}, 32'd0);
        chk("busy in done", {31'd0, busy}, 32'd0);
        chk("RD in done", {31'd0, RD}, 32'd0);
        done_cyc = cyc;
        @(posedge Clk); #1; cyc++;
        chk("done width", {31'd0, done}, 32'd0);
        chk("valid back idle", {31'd0, out_valid}, 32'd0);
        chk("busy back idle", {31'd0, busy}, 32'd0);
        finished = 1;
      end
    end
    if (!finished) begin
      n_checks++; n_fail++;
      $display("FAIL job timeout: got no completion by cycle %0d required done", cyc);
    end
  endtask

  typedef struct {
    logic [31:0] vb, cb, cs;
    logic [15:0] vs, nc;
    int          exp_pairs, exp_done;
    logic [31:0] exp_la1, exp_la2;
  } vec_t;

  vec_t vecs[6];
  int   pairs, done_cyc;
  logic [31:0] la1, la2;

  initial begin
    vecs[0] = '{32'd2, 32'd180, 32'd26, 16'd16, 16'd1, 16, 17, 32'd195, 32'd17};
    vecs[1] = '{32'd2, 32'd180, 32'd26, 16'd16, 16'd2, 32, 33, 32'd221, 32'd17};
    vecs[2] = '{32'd5, 32'd9, 32'd4, 16'd0, 16'd3, 0, 1, 32'd0, 32'd0};
    vecs[3] = '{32'd5, 32'd9, 32'd4, 16'd4, 16'd0, 0, 1, 32'd0, 32'd0};
    vecs[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFF0, 32'd8, 16'd3, 16'd3, 9, 10, 32'd2, 32'd0};
    vecs[5] = '{32'd10, 32'd20, 32'd5, 16'd1, 16'd1, 1, 2, 32'd20, 32'd10};

    Rst = 1'b0; start = 1'b0; out_ready = 1'b0;
    vb_in = '0; cb_in = '0; cs_in = '0; vs_in = '0; nc_in = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk_idle("reset");
    Rst = 1'b1; out_ready = 1'b1;
    @(posedge Clk); #1;
    chk("ready while idle", {31'd0, out_valid}, 32'd0);

    for (int k = 0; k < 6; k++) begin
      run_job(vecs[k].vb, vecs[k].cb, vecs[k].cs, vecs[k].vs, vecs[k].nc, -1, 0, -1, -1,
              pairs, done_cyc, la1, la2);
      chk($sformatf("vec%0d pairs", k), pairs, vecs[k].exp_pairs);
      chk($sformatf("vec%0d done cycle", k), done_cyc, vecs[k].exp_done);
      if (vecs[k].exp_pairs > 0) begin
        chk($sformatf("vec%0d last addr1", k), la1, vecs[k].exp_la1);
        chk($sformatf("vec%0d last addr2", k), la2, vecs[k].exp_la2);
      end
    end

    // Backpressure for 3 cycles at i=5.
    run_job(32'd2, 32'd180, 32'd26, 16'd16, 16'd1, 5, 3, -1, -1, pairs, done_cyc, la1, la2);
    chk("stall pairs", pairs, 16);
    chk("stall done cycle", done_cyc, 20);
    chk("stall last addr1", la1, 32'd195);

    // Second start at i=8 with col_base=0 must be ignored.
    run_job(32'd2, 32'd180, 32'd26, 16'd16, 16'd1, -1, 0, 8, -1, pairs, done_cyc, la1, la2);
    chk("restart pairs", pairs, 16);
    chk("restart done cycle", done_cyc, 17);
    chk("restart last addr1", la1, 32'd195);

    // Reset at i=10 abandons the job, then a fresh job runs cleanly.
    run_job(32'd2, 32'd180, 32'd26, 16'd16, 16'd1, -1, 0, -1, 10, pairs, done_cyc, la1, la2);
    chk("reset pairs", pairs, 10);
    chk("reset no done", done_cyc, -1);
    run_job(32'd2, 32'd180, 32'd26, 16'd16, 16'd1, -1, 0, -1, -1, pairs, done_cyc, la1, la2);
    chk("post-reset pairs", pairs, 16);
    chk("post-reset done cycle", done_cyc, 17);
    chk("post-reset last addr2", la2, 32'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
